control_carrera: RTL
====================

# control_carrera

Race-sequencing controller for the line-follower stopwatch. It syncs the start button, abort button and finish-line sensor. It drives the stopwatch's `reset_timer` and `enable_timer` inputs and counts laps. It captures the split time on each line crossing and ends the run on the last lap or on the 9:59.99 ceiling. It sits between the board inputs and the stopwatch counter; its split outputs feed the display mux.

## Interface
- `NUM_LAPS`, 3: laps per run, range 1..15.
- `HOLDOFF_CYCLES`, 12_500_000: clk cycles after an accepted sensor event during which further sensor edges are ignored (0.5 s at 25 MHz).
- `clk` in 1: system clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `btn_start` in 1: start/re-arm request, active-high, asynchronous.
- `btn_abort` in 1: abort request, active-high, asynchronous.
- `sensor_meta` in 1: finish-line sensor, high = line detected, asynchronous.
- `minutos` in 4: live stopwatch minutes.
- `segundos` in 6: live stopwatch seconds.
- `centesimas` in 7: live stopwatch hundredths.
- `reset_timer` out 1: stopwatch clear, registered.
- `enable_timer` out 1: stopwatch run, registered.
- `estado` out 2: FSM state; IDLE=0, ARMED=1, RUNNING=2, FINISHED=3.
- `vueltas` out 4: completed laps.
- `split_min` out 4, `split_seg` out 6, `split_cent` out 7: last captured split (cumulative time).
- `split_valid` out 1: one-cycle pulse on each capture.
- `timeout` out 1: run ended by ceiling, not by laps.

## Operation
- Each asynchronous input passes through a 2-FF synchronizer plus one history FF. An event is a rising edge of the synchronized signal. Level-high inputs produce exactly one event.
- IDLE: `reset_timer`=1 and `enable_timer`=0. A start event moves to ARMED.
- ARMED: `reset_timer`=1 and `enable_timer`=0. Split registers, `vueltas` and `timeout` are cleared on entry. A sensor event moves to RUNNING, loads the holdoff counter and captures nothing. Repeated start events are ignored.
- RUNNING: `reset_timer`=0 and `enable_timer`=1.
  - A sensor event with holdoff counter = 0 is accepted:
    - split ← {`minutos`, `segundos`, `centesimas`} as sampled on the accepting edge;
    - `vueltas`+1;
    - `split_valid`=1 for 1 cycle;
    - holdoff counter reloads to `HOLDOFF_CYCLES`.
  - If the new `vueltas` equals `NUM_LAPS`, go to FINISHED.
  - A sensor event with holdoff counter ≠ 0 is dropped with no state change.
  - Holdoff counter decrements to 0 and saturates there.
- Ceiling: in RUNNING, when the inputs read 9:59.99, go to FINISHED with `timeout`=1.
- FINISHED: `reset_timer`=0 and `enable_timer`=0, so the display holds the frozen time. A start event moves to ARMED.
- Abort event in any state: go to IDLE. Split registers are kept, `timeout` is kept, and `vueltas` is kept.
- Priority on the same edge: `reset_n` > abort > sensor/ceiling > start.
- Sensor accept and ceiling on the same edge:
  - capture the split, increment `vueltas` and go to FINISHED;
  - `timeout`=1 only if the new `vueltas` < `NUM_LAPS`.
- `vueltas` never exceeds `NUM_LAPS`. The split is captured with no arithmetic.

## Timing
- Reset (`reset_n`=0 at an edge): the following take effect on that edge.
  - `estado`=IDLE, `reset_timer`=1, `enable_timer`=0.
  - `vueltas`=0, splits=0, `split_valid`=0, `timeout`=0.
  - Synchronizer and history FFs are cleared to 0; the holdoff counter is cleared to 0.
- A reset mid-run aborts immediately, with no capture.
- Input latency: a raw input high at edge k is registered in sync1 at k and sync2 at k+1. The event is seen combinationally after k+1, and the state and outputs update at edge k+2.
- `reset_timer`, `enable_timer` and `estado` change on the same edge as the transition. The stopwatch sees the new controls one edge later.
- `split_valid` is high for exactly the cycle after the capturing edge. The split registers are valid from that cycle onward.
- The holdoff counter reaches 0 exactly `HOLDOFF_CYCLES` edges after the accepting edge. A sensor event seen in that cycle is accepted.

## Test plan
All scenarios use `NUM_LAPS`=2 and `HOLDOFF_CYCLES`=8.

- Hold `reset_n`=0 for 2 edges → `estado`=0, `reset_timer`=1, `enable_timer`=0, `vueltas`=0, `timeout`=0.
- Pulse `btn_start` high 1 cycle, then `sensor_meta` high → `estado`=1 at the 3rd edge after the start pulse. `estado`=2 and `enable_timer`=1 at the 3rd edge after the sensor goes high.
- In RUNNING, hold inputs 0:12.34 and send a sensor event 20 cycles after the start crossing → split=0/12/34, `vueltas`=1, `split_valid` high exactly 1 cycle. A second sensor event 4 cycles later → ignored, `vueltas` stays 1.
- Send a sensor event 10 cycles after the lap-1 capture, with inputs 0:25.07 → split=0/25/07, `vueltas`=2, `estado`=3, `enable_timer`=0, `timeout`=0. Then a start event → `estado`=1, `vueltas`=0, split=0.
- In RUNNING with `vueltas`=0, drive 9:59.99 → `estado`=3, `timeout`=1, `enable_timer`=0. Repeat with a sensor event accepted on the same edge → `vueltas`=1, split=9/59/99, `timeout`=1.
- In RUNNING, pulse `btn_abort` together with a sensor event → `estado`=0, `reset_timer`=1, no capture. Separately, pull `reset_n` low mid-run → all outputs return to their reset values on that edge.

Source files
------------

// File: rtl/control_carrera.sv
// Race-sequencing controller: synchronizes the board inputs, drives the stopwatch
// run/clear controls, counts laps, captures split times and detects the 9:59.99 ceiling.
module control_carrera #(
    parameter int NUM_LAPS       = 3,
    parameter int HOLDOFF_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_start,
    input  logic       btn_abort,
    input  logic       sensor_meta,
    input  logic [3:0] minutos,
    input  logic [5:0] segundos,
    input  logic [6:0] centesimas,
    output logic       reset_timer,
    output logic       enable_timer,
    output logic [1:0] estado,
    output logic [3:0] vueltas,
    output logic [3:0] split_min,
    output logic [5:0] split_seg,
    output logic [6:0] split_cent,
    output logic       split_valid,
    output logic       timeout
);

    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [HW-1:0] HOLDOFF_LOAD = HW'(HOLDOFF_CYCLES);
    localparam logic [3:0]    LAPS_MAX     = 4'(NUM_LAPS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        RUNNING  = 2'd2,
        FINISHED = 2'd3
    } state_t;

    state_t        state;
    logic [2:0]    sync1, sync2, hist;   // bit order: {abort, start, sensor}
    logic [HW-1:0] holdoff;

    logic       ev_abort, ev_start, ev_sensor;
    logic       at_ceiling, accept;
    logic [3:0] laps_next;

    assign ev_sensor  = sync2[0] & ~hist[0];
    assign ev_start   = sync2[1] & ~hist[1];
    assign ev_abort   = sync2[2] & ~hist[2];
    assign at_ceiling = (minutos == 4'd9) && (segundos == 6'd59) && (centesimas == 7'd99);
    assign accept     = ev_sensor && (holdoff == '0);
    assign laps_next  = vueltas + 4'd1;
    assign estado     = state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            sync1        <= '0;
            sync2        <= '0;
            hist         <= '0;
            holdoff      <= '0;
            reset_timer  <= 1'b1;
            enable_timer <= 1'b0;
            vueltas      <= '0;
            split_min    <= '0;
            split_seg    <= '0;
            split_cent   <= '0;
            split_valid  <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            sync1       <= {btn_abort, btn_start, sensor_meta};
            sync2       <= sync1;
            hist        <= sync2;
            split_valid <= 1'b0;
            if (holdoff != '0) holdoff <= holdoff - HW'(1);

            if (ev_abort) begin
                // Abort keeps the last result on the display outputs.
                state        <= IDLE;
                reset_timer  <= 1'b1;
                enable_timer <= 1'b0;
            end else begin
                case (state)
                    IDLE, FINISHED: begin
                        if (ev_start) begin
                            state        <= ARMED;
                            reset_timer  <= 1'b1;
                            enable_timer <= 1'b0;
                            vueltas      <= '0;
                            split_min    <= '0;
                            split_seg    <= '0;
                            split_cent   <= '0;
                            timeout      <= 1'b0;
                        end
                    end
                    ARMED: begin
                        // The start crossing only launches the run; nothing is captured.
                        if (ev_sensor) begin
                            state        <= RUNNING;
                            reset_timer  <= 1'b0;
                            enable_timer <= 1'b1;
                            holdoff      <= HOLDOFF_LOAD;
                        end
                    end
                    RUNNING: begin
                        if (accept) begin
                            split_min   <= minutos;
                            split_seg   <= segundos;
                            split_cent  <= centesimas;
                            split_valid <= 1'b1;
                            vueltas     <= laps_next;
                            holdoff     <= HOLDOFF_LOAD;
                            if (laps_next == LAPS_MAX || at_ceiling) begin
                                state        <= FINISHED;
                                enable_timer <= 1'b0;
                                timeout      <= at_ceiling && (laps_next < LAPS_MAX);
                            end
                        end else if (at_ceiling) begin
                            state        <= FINISHED;
                            enable_timer <= 1'b0;
                            timeout      <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
